scandoubler_vidmem_port: RTL and testbench
==========================================

# scandoubler_vidmem_port

Memory-side responder for the scandoubler rotation interface. It serves the scandoubler's `vidin` write bursts (16 words) and `vidout` read bursts (8 words) and turns each burst into single-word transactions on a generic 16-bit RAM client port. It sits between the scandoubler and the SDRAM arbiter, so the scandoubler never sees RAM latency directly.

## Interface
- `ADDR_WIDTH`, default 22: word-address width of the RAM client port.
- `BASE_ADDR`, default 0: word offset of the framebuffer region.
- `WD_LIMIT`, default 255: watchdog cycle limit. Only used with the watchdog macro.

Ports:
- `clk_sys` in 1: system clock; everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vidin_req` in 1: write burst requested.
- `vidin_frame` in 1, `vidin_row` in 10, `vidin_col` in 10: write burst address. Stable while `vidin_req` is high.
- `vidin_d` in 16: current write word.
- `vidin_ack` out 1: one-cycle pulse meaning the current word is consumed.
- `vidout_req` in 1: read burst requested.
- `vidout_frame` in 1, `vidout_row` in 10, `vidout_col` in 10: read burst address.
- `vidout_d` out 16: read word.
- `vidout_ack` out 1: one-cycle pulse meaning `vidout_d` is valid.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_WIDTH, `mem_d` out 16: RAM request.
- `mem_q` in 16, `mem_ack` in 1: RAM completion. `mem_q` is valid with `mem_ack` on reads.
- `wd_err` out 1: sticky watchdog flag.

## Operation
- Word address = `BASE_ADDR + {frame, row, col + i}`.
  - `i` is the word index within the burst.
  - `col + i` wraps at 10 bits.
  - The sum wraps modulo 2^ADDR_WIDTH.
  - The 21-bit concatenation is zero-extended.
- States:
  - IDLE: if `vidout_req` is high, go to RD. Else if `vidin_req` is high, go to WR. On entry, latch frame, row and col, and clear `i`.
  - WR: assert `mem_req=1`, `mem_we=1`, and `mem_d` = `vidin_d` registered at issue. On `mem_ack`, pulse `vidin_ack` and increment `i`. After the 16th ack, go to WR_END.
  - RD: assert `mem_req=1`, `mem_we=0`. On `mem_ack`, register `mem_q` into `vidout_d`, pulse `vidout_ack` and increment `i`. After the 8th ack, go to RD_END.
  - WR_END / RD_END: wait for the matching req to go low, then go to IDLE. A held-high req never starts a second burst.
- Arbitration:
  - Read has priority when both reqs are high in IDLE (display timing is the critical path).
  - There is no preemption mid-burst.
  - A req already high when the other burst ends is served next.
- Request deasserted mid-burst (protocol violation): finish the outstanding RAM word, then go to IDLE. No further acks are issued.
- Reset asserted mid-burst: go to IDLE immediately and drop `mem_req`. The RAM side tolerates an abandoned request.
- Reset value of every output is 0: `vidin_ack`, `vidout_ack`, `vidout_d`, `mem_req`, `mem_we`, `mem_addr`, `mem_d`, `wd_err`.

## Timing
- Cycle T: a req is sampled high in IDLE. At T+1: `mem_req`, `mem_we`, `mem_addr` and `mem_d` are valid.
- RAM request handshake:
  - `mem_req` stays high with all fields stable until the cycle `mem_ack` is sampled high.
  - At `mem_ack` in cycle N, `mem_req` is low at N+1, as is the `vidin_ack` or `vidout_ack` pulse.
  - The next word issues at N+2, with `vidin_d` sampled at N+1 (the scandoubler advances its data on the ack).
- Minimum rate is 1 word per 2 cycles with zero-wait RAM (`mem_ack` in the first `mem_req` cycle).
- `vidout_d` holds its value until the next read ack.
- A burst end at 16th/8th ack in cycle N: the END state is entered at N+1. IDLE is reached at the earliest in the cycle after the req is seen low.

## Configuration
- `SCANDOUBLER_VIDMEM_WATCHDOG_EN` defined:
  - A counter runs while `mem_req` is high without `mem_ack`.
  - When it reaches `WD_LIMIT`: drop `mem_req`, abandon the burst (no further acks), go to the END state, and set `wd_err`.
  - `wd_err` clears only on reset.
- Undefined: no counter, unlimited wait for `mem_ack`, `wd_err` tied to 0.

## Test plan
- Write burst: frame=1, row=5, col=32, `BASE_ADDR=0`, zero-wait RAM, `vidin_d` = 0xA000+i → 16 writes at addresses 0x101420..0x10142F with data 0xA000..0xA00F; exactly 16 `vidin_ack` pulses; then no activity while req is held high.
- Read burst: row=0, col=1020, RAM returns address low bits → 8 reads at cols 1020..1023 then 0..3 (wrap); 8 `vidout_ack` pulses, each with `vidout_d` equal to the returned `mem_q`.
- Both reqs rise in the same cycle → the read burst completes first (8 acks), then the write burst (16 acks).
- RAM acks after 3 wait cycles → `mem_req` fields stay stable for 4 cycles and each ack pulse is exactly 1 cycle.
- `reset_n` low after the 5th write ack → all outputs 0 asynchronously; after release with req high, a new burst restarts at i=0.
- With `SCANDOUBLER_VIDMEM_WATCHDOG_EN` and `WD_LIMIT=255`, RAM never acks → `mem_req` drops after 255 cycles, `wd_err`=1 sticky, and no `vidin_ack` or `vidout_ack`.

Source files
------------

// File: rtl/scandoubler_vidmem_port_if.sv
// Scandoubler rotation bus plus RAM client port, grouped for one connection.
// slave: the memory-side responder view; master: scandoubler + RAM view.
interface scandoubler_vidmem_port_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  vidin_req;
    logic                  vidin_frame;
    logic [9:0]            vidin_row;
    logic [9:0]            vidin_col;
    logic [15:0]           vidin_d;
    logic                  vidin_ack;
    logic                  vidout_req;
    logic                  vidout_frame;
    logic [9:0]            vidout_row;
    logic [9:0]            vidout_col;
    logic [15:0]           vidout_d;
    logic                  vidout_ack;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_d;
    logic [15:0]           mem_q;
    logic                  mem_ack;

    modport slave (
        input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
        output vidin_ack,
        input  vidout_req, vidout_frame, vidout_row, vidout_col,
        output vidout_d, vidout_ack,
        output mem_req, mem_we, mem_addr, mem_d,
        input  mem_q, mem_ack
    );

    modport master (
        output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
        input  vidin_ack,
        output vidout_req, vidout_frame, vidout_row, vidout_col,
        input  vidout_d, vidout_ack,
        input  mem_req, mem_we, mem_addr, mem_d,
        output mem_q, mem_ack
    );
endinterface

// File: rtl/scandoubler_vidmem_port.sv
// Splits scandoubler write (16 word) / read (8 word) bursts into single RAM words.
// Ports: clk_sys, reset_n (async low), bus (slave modport), wd_err (sticky).
// Optional watchdog: define SCANDOUBLER_VIDMEM_WATCHDOG_EN.
module scandoubler_vidmem_port #(
    parameter int                    ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WD_LIMIT   = 255
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    scandoubler_vidmem_port_if.slave  bus,
    output logic                      wd_err
);

`ifdef SCANDOUBLER_VIDMEM_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WR, RD, WR_END, RD_END
    } state_t;

    state_t                r_state, w_state;
    logic                  r_frame, w_frame;
    logic [9:0]            r_row, w_row;
    logic [9:0]            r_col, w_col;
    logic [3:0]            r_idx, w_idx;
    logic                  r_mem_req, w_mem_req;
    logic                  r_mem_we, w_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [15:0]           r_mem_d, w_mem_d;
    logic [15:0]           r_vidout_d, w_vidout_d;
    logic                  r_vidin_ack, w_vidin_ack;
    logic                  r_vidout_ack, w_vidout_ack;
    logic                  r_wd_err, w_wd_err;
    logic [15:0]           r_wd_cnt, w_wd_cnt;
    logic                  w_timeout;

    function automatic logic [ADDR_WIDTH-1:0] f_addr(
        input logic f, input logic [9:0] row,
        input logic [9:0] col, input logic [3:0] idx
    );
        logic [9:0]  c;
        logic [20:0] cat;
        c   = col + {6'd0, idx};
        cat = {f, row, c};
        return BASE_ADDR + ADDR_WIDTH'(cat);
    endfunction

    // Counter only advances while a request waits; compiled out when disabled.
    assign w_timeout = WdEn && r_mem_req && !bus.mem_ack &&
                       (r_wd_cnt == 16'(WD_LIMIT - 1));

    always_comb begin
        w_state      = r_state;
        w_frame      = r_frame;
        w_row        = r_row;
        w_col        = r_col;
        w_idx        = r_idx;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_d      = r_mem_d;
        w_vidout_d   = r_vidout_d;
        w_vidin_ack  = 1'b0;
        w_vidout_ack = 1'b0;
        w_wd_err     = r_wd_err;
        w_wd_cnt     = (WdEn && r_mem_req && !bus.mem_ack) ?
                       r_wd_cnt + 16'd1 : 16'd0;
        unique case (r_state)
            IDLE: begin
                if (bus.vidout_req) begin
                    w_state    = RD;
                    w_frame    = bus.vidout_frame;
                    w_row      = bus.vidout_row;
                    w_col      = bus.vidout_col;
                    w_idx      = 4'd0;
                    w_mem_req  = 1'b1;
                    w_mem_we   = 1'b0;
                    w_mem_addr = f_addr(bus.vidout_frame, bus.vidout_row,
                                        bus.vidout_col, 4'd0);
                end else if (bus.vidin_req) begin
                    w_state    = WR;
                    w_frame    = bus.vidin_frame;
                    w_row      = bus.vidin_row;
                    w_col      = bus.vidin_col;
                    w_idx      = 4'd0;
                    w_mem_req  = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_d    = bus.vidin_d;
                    w_mem_addr = f_addr(bus.vidin_frame, bus.vidin_row,
                                        bus.vidin_col, 4'd0);
                end
            end
            WR: begin
                if (r_mem_req) begin
                    if (bus.mem_ack) begin
                        w_mem_req = 1'b0;
                        // A dropped req still retires the RAM word, but silently.
                        if (bus.vidin_req) begin
                            w_vidin_ack = 1'b1;
                            w_idx       = r_idx + 4'd1;
                            if (r_idx == 4'd15) w_state = WR_END;
                        end else begin
                            w_state = IDLE;
                        end
                    end else if (w_timeout) begin
                        w_mem_req = 1'b0;
                        w_wd_err  = 1'b1;
                        w_state   = WR_END;
                    end
                end else if (bus.vidin_req) begin
                    // Gap cycle after an ack: scandoubler has advanced vidin_d.
                    w_mem_req  = 1'b1;
                    w_mem_d    = bus.vidin_d;
                    w_mem_addr = f_addr(r_frame, r_row, r_col, r_idx);
                end else begin
                    w_state = IDLE;
                end
            end
            RD: begin
                if (r_mem_req) begin
                    if (bus.mem_ack) begin
                        w_mem_req = 1'b0;
                        if (bus.vidout_req) begin
                            w_vidout_d   = bus.mem_q;
                            w_vidout_ack = 1'b1;
                            w_idx        = r_idx + 4'd1;
                            if (r_idx == 4'd7) w_state = RD_END;
                        end else begin
                            w_state = IDLE;
                        end
                    end else if (w_timeout) begin
                        w_mem_req = 1'b0;
                        w_wd_err  = 1'b1;
                        w_state   = RD_END;
                    end
                end else if (bus.vidout_req) begin
                    w_mem_req  = 1'b1;
                    w_mem_addr = f_addr(r_frame, r_row, r_col, r_idx);
                end else begin
                    w_state = IDLE;
                end
            end
            WR_END: if (!bus.vidin_req) w_state = IDLE;
            RD_END: if (!bus.vidout_req) w_state = IDLE;
            default: w_state = IDLE;
        endcase
        if (w_timeout) w_wd_cnt = 16'd0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_frame      <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_idx        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_d      <= '0;
            r_vidout_d   <= '0;
            r_vidin_ack  <= 1'b0;
            r_vidout_ack <= 1'b0;
            r_wd_err     <= 1'b0;
            r_wd_cnt     <= '0;
        end else begin
            r_state      <= w_state;
            r_frame      <= w_frame;
            r_row        <= w_row;
            r_col        <= w_col;
            r_idx        <= w_idx;
            r_mem_req    <= w_mem_req;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_d      <= w_mem_d;
            r_vidout_d   <= w_vidout_d;
            r_vidin_ack  <= w_vidin_ack;
            r_vidout_ack <= w_vidout_ack;
            r_wd_err     <= w_wd_err;
            r_wd_cnt     <= w_wd_cnt;
        end
    end

    assign bus.vidin_ack  = r_vidin_ack;
    assign bus.vidout_ack = r_vidout_ack;
    assign bus.vidout_d   = r_vidout_d;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_d      = r_mem_d;
    assign wd_err         = r_wd_err;

endmodule

// File: tb/tb_scandoubler_vidmem_port.sv
// Self-checking bench: scoreboarded RAM model and scandoubler stimulus.
// Covers write/read bursts, column wrap, priority, wait states and reset.
module tb_scandoubler_vidmem_port;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] data;
    } mem_tr_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic wd_err;

    scandoubler_vidmem_port_if #(.ADDR_WIDTH(22)) bus ();

    scandoubler_vidmem_port #(
        .ADDR_WIDTH(22), .BASE_ADDR(22'd0), .WD_LIMIT(255)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus),
        .wd_err  (wd_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    mem_tr_t     mq[$];
    logic [15:0] rq[$];

    function automatic logic [21:0] ea(input logic f, input logic [9:0] r,
                                       input logic [9:0] c, input int i);
        logic [9:0] cc;
        cc = c + 10'(i);
        return {1'b0, f, r, cc};
    endfunction

    task automatic push_burst(input logic we, input logic f,
                              input logic [9:0] r, input logic [9:0] c,
                              input int n, input logic [15:0] dbase);
        mem_tr_t t;
        for (int i = 0; i < n; i++) begin
            t.we   = we;
            t.addr = ea(f, r, c, i);
            t.data = we ? dbase + 16'(i) : 16'h0;
            mq.push_back(t);
            if (!we) rq.push_back(t.addr[15:0]);
        end
    endtask

    // RAM model: acks after ram_wait extra cycles, returns low address bits.
    int          ram_wait  = 0;
    bit          ram_never = 1'b0;
    logic        ram_ack   = 1'b0;
    logic [15:0] ram_q     = '0;
    bit          busy      = 1'b0;
    int          wc        = 0;
    logic [21:0] fa;
    logic [15:0] fd;
    logic        fw;
    mem_tr_t     et;

    assign bus.mem_ack = ram_ack;
    assign bus.mem_q   = ram_q;

    always @(negedge clk_sys) begin
        if (ram_ack) begin
            ram_ack = 1'b0;
            busy    = 1'b0;
            wc      = 0;
        end else if (bus.mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                wc   = 0;
                fa   = bus.mem_addr;
                fd   = bus.mem_d;
                fw   = bus.mem_we;
            end
            if (!ram_never && wc == ram_wait) begin
                if (ram_wait > 0) begin
                    chk("stable_addr", 32'(bus.mem_addr), 32'(fa));
                    chk("stable_d", 32'(bus.mem_d), 32'(fd));
                    chk("stable_we", 32'(bus.mem_we), 32'(fw));
                end
                chk("sb_mem_nonempty", 32'(mq.size() != 0), 32'd1);
                if (mq.size() != 0) begin
                    et = mq.pop_front();
                    chk("mem_we", 32'(bus.mem_we), 32'(et.we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(et.addr));
                    if (et.we) chk("mem_d", 32'(bus.mem_d), 32'(et.data));
                end
                ram_q   = bus.mem_addr[15:0];
                ram_ack = 1'b1;
            end else begin
                wc++;
            end
        end else begin
            busy = 1'b0;
            wc   = 0;
        end
    end

    // Ack monitor + scandoubler data advance.
    int   n_win = 0, n_rd = 0, n_iss = 0;
    logic p_win = 1'b0, p_rd = 1'b0, p_req = 1'b0;
    logic [15:0] ev;

    always @(negedge clk_sys) begin
        if (bus.vidin_ack) begin
            n_win++;
            chk("win_pulse", 32'(p_win), 32'd0);
            bus.vidin_d = bus.vidin_d + 16'd1;
        end
        if (bus.vidout_ack) begin
            n_rd++;
            chk("rd_pulse", 32'(p_rd), 32'd0);
            chk("sb_rd_nonempty", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                ev = rq.pop_front();
                chk("vidout_d", 32'(bus.vidout_d), 32'(ev));
            end
        end
        if (bus.mem_req && !p_req) n_iss++;
        p_win = bus.vidin_ack;
        p_rd  = bus.vidout_ack;
        p_req = bus.mem_req;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_vidin_ack"}, 32'(bus.vidin_ack), 32'd0);
        chk({tag, "_vidout_ack"}, 32'(bus.vidout_ack), 32'd0);
        chk({tag, "_vidout_d"}, 32'(bus.vidout_d), 32'd0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_d"}, 32'(bus.mem_d), 32'd0);
        chk({tag, "_wd_err"}, 32'(wd_err), 32'd0);
    endtask

    task automatic wait_cnt(input string tag, input int which,
                            input int target);
        int k;
        k = 0;
        while (k < 3000 && ((which == 0) ? n_win : n_rd) < target) begin
            @(posedge clk_sys);
            #1;
            k++;
        end
        chk(tag, 32'((which == 0) ? n_win : n_rd), 32'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    int b_win, b_rd, b_iss, hi;

    initial begin
        bus.vidin_req    = 0; bus.vidin_frame  = 0;
        bus.vidin_row    = 0; bus.vidin_col    = 0;
        bus.vidin_d      = 0; bus.vidout_req   = 0;
        bus.vidout_frame = 0; bus.vidout_row   = 0;
        bus.vidout_col   = 0;
        #12;
        chk_zero("rst");
        idle(1);
        reset_n = 1'b1;
        idle(2);

        // Write burst, zero-wait RAM, then req held high.
        b_win = n_win; b_iss = n_iss;
        push_burst(1'b1, 1'b1, 10'd5, 10'd32, 16, 16'hA000);
        bus.vidin_frame = 1; bus.vidin_row = 5; bus.vidin_col = 32;
        bus.vidin_d = 16'hA000; bus.vidin_req = 1;
        wait_cnt("wr_acks", 0, b_win + 16);
        idle(20);
        chk("wr_ack_total", 32'(n_win - b_win), 32'd16);
        chk("wr_no_extra_issue", 32'(n_iss - b_iss), 32'd16);
        bus.vidin_req = 0;
        idle(3);

        // Read burst with column wrap.
        b_rd = n_rd;
        push_burst(1'b0, 1'b0, 10'd0, 10'd1020, 8, 16'h0);
        bus.vidout_frame = 0; bus.vidout_row = 0; bus.vidout_col = 1020;
        bus.vidout_req = 1;
        wait_cnt("rd_acks", 1, b_rd + 8);
        idle(5);
        chk("rd_ack_total", 32'(n_rd - b_rd), 32'd8);
        chk("rd_hold_d", 32'(bus.vidout_d), 32'h3);
        bus.vidout_req = 0;
        idle(3);

        // Both reqs together: read first, then write.
        b_rd = n_rd; b_win = n_win;
        push_burst(1'b0, 1'b0, 10'd2, 10'd0, 8, 16'h0);
        push_burst(1'b1, 1'b1, 10'd3, 10'd100, 16, 16'hB000);
        bus.vidout_row = 2; bus.vidout_col = 0;
        bus.vidin_frame = 1; bus.vidin_row = 3; bus.vidin_col = 100;
        bus.vidin_d = 16'hB000;
        bus.vidout_req = 1; bus.vidin_req = 1;
        wait_cnt("both_rd", 1, b_rd + 8);
        chk("both_wr_waits", 32'(n_win - b_win), 32'd0);
        bus.vidout_req = 0;
        wait_cnt("both_wr", 0, b_win + 16);
        bus.vidin_req = 0;
        idle(3);

        // Three wait states per word.
        ram_wait = 3;
        b_win = n_win;
        push_burst(1'b1, 1'b0, 10'd7, 10'd1000, 16, 16'hC000);
        bus.vidin_frame = 0; bus.vidin_row = 7; bus.vidin_col = 1000;
        bus.vidin_d = 16'hC000; bus.vidin_req = 1;
        @(posedge clk_sys); #1;
        hi = 0;
        while (bus.mem_req && hi < 20) begin
            hi++;
            @(posedge clk_sys); #1;
        end
        chk("wait_req_cycles", 32'(hi), 32'd4);
        wait_cnt("wait_acks", 0, b_win + 16);
        bus.vidin_req = 0;
        ram_wait = 0;
        idle(3);

        // Reset after the 5th write ack, restart from i=0.
        b_win = n_win;
        push_burst(1'b1, 1'b1, 10'd9, 10'd0, 16, 16'hD000);
        bus.vidin_frame = 1; bus.vidin_row = 9; bus.vidin_col = 0;
        bus.vidin_d = 16'hD000; bus.vidin_req = 1;
        wait_cnt("pre_rst_acks", 0, b_win + 5);
        reset_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        chk("sb_left", 32'(mq.size()), 32'd11);
        mq.delete();
        idle(2);
        b_win = n_win;
        push_burst(1'b1, 1'b1, 10'd9, 10'd0, 16, 16'hD000);
        bus.vidin_d = 16'hD000;
        reset_n = 1'b1;
        wait_cnt("post_rst_acks", 0, b_win + 16);
        bus.vidin_req = 0;
        idle(3);
        chk("sb_mem_drained", 32'(mq.size()), 32'd0);
        chk("sb_rd_drained", 32'(rq.size()), 32'd0);

`ifdef SCANDOUBLER_VIDMEM_WATCHDOG_EN
        ram_never = 1'b1;
        b_win = n_win; b_rd = n_rd;
        bus.vidin_req = 1;
        @(posedge clk_sys); #1;
        hi = 0;
        while (bus.mem_req && hi < 1000) begin
            hi++;
            @(posedge clk_sys); #1;
        end
        chk("wd_req_cycles", 32'(hi), 32'd255);
        chk("wd_err_set", 32'(wd_err), 32'd1);
        idle(10);
        chk("wd_no_reissue", 32'(bus.mem_req), 32'd0);
        bus.vidin_req = 0;
        idle(5);
        chk("wd_err_sticky", 32'(wd_err), 32'd1);
        chk("wd_no_acks", 32'((n_win - b_win) + (n_rd - b_rd)), 32'd0);
`else
        chk("wd_err_off", 32'(wd_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
